// File: rtl/data_ram_ctrl.sv
// ----------------------------------------------------------------------------
// data_ram_ctrl
//   Responder end of the MEM-stage data-RAM interface. Takes the memory
//   stage's combinational request, runs it against an external asynchronous
//   32-bit SRAM with WAIT_CYCLES extra access cycles, and holds the pipeline
//   until the access has finished. Loads return the full word; lane
//   extraction and extension stay in the memory stage.
//
// Parameters
//   ADDR_WIDTH   word-address bits driven to the SRAM
//   WAIT_CYCLES  extra SRAM access cycles (0..15)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ram_en_i                 request valid
//   mem_write_en_i           1 = store, 0 = load
//   mem_addr_i               byte address, [1:0] ignored
//   mem_select_i             byte lanes, bit3 = data[31:24]
//   store_data_i             lane-replicated store data
//   excp_i                   exception on the current instruction, drops request
//   ram_data_o               last completed read word
//   stall_o                  hold pipeline (request inputs must stay stable)
//   sram_addr_o/wdata_o      SRAM word address / write data (held between accesses)
//   sram_wdata_oe_o          tri-state enable for write data
//   sram_rdata_i             SRAM read data
//   sram_ce_n_o/oe_n_o/we_n_o/be_n_o  active-low SRAM controls
// ----------------------------------------------------------------------------
module data_ram_ctrl #(
    parameter int ADDR_WIDTH  = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ram_en_i,
    input  logic                  mem_write_en_i,
    input  logic [31:0]           mem_addr_i,
    input  logic [3:0]            mem_select_i,
    input  logic [31:0]           store_data_i,
    input  logic                  excp_i,
    output logic [31:0]           ram_data_o,
    output logic                  stall_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [31:0]           sram_wdata_o,
    output logic                  sram_wdata_oe_o,
    input  logic [31:0]           sram_rdata_i,
    output logic                  sram_ce_n_o,
    output logic                  sram_oe_n_o,
    output logic                  sram_we_n_o,
    output logic [3:0]            sram_be_n_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [3:0] WAIT_LOAD = WAIT_CYCLES[3:0];

    logic [1:0] state;
    logic [3:0] cnt;
    logic [3:0] sel_q;
    logic       write_q;
    logic       accept;
    logic       in_access;

    // Byte-offset bits and address bits above the SRAM range are not used.
    logic unused_addr;
    assign unused_addr = ^{mem_addr_i[1:0], mem_addr_i[31:ADDR_WIDTH+2]};

    // An excepting instruction must never touch memory.
    assign accept = ram_en_i && !excp_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            sel_q        <= 4'd0;
            write_q      <= 1'b0;
            sram_addr_o  <= '0;
            sram_wdata_o <= 32'd0;
            ram_data_o   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sram_addr_o  <= mem_addr_i[ADDR_WIDTH+1:2];
                        sram_wdata_o <= store_data_i;
                        sel_q        <= mem_select_i;
                        write_q      <= mem_write_en_i;
                        cnt          <= WAIT_LOAD;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Request inputs are no longer looked at; the latched
                    // access runs to completion.
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!write_q) ram_data_o <= sram_rdata_i;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Controls are combinational from state so they drop the same cycle
    // reset is raised, even mid-access.
    assign in_access = (state == ACCESS) && !rst;

    assign stall_o         = !rst && ((state == IDLE && accept) || state == ACCESS);
    assign sram_ce_n_o     = !in_access;
    assign sram_oe_n_o     = !(in_access && !write_q);
    assign sram_we_n_o     = !(in_access && write_q);
    assign sram_wdata_oe_o = in_access && write_q;
    // Loads always read the full word; stores enable only the selected lanes.
    assign sram_be_n_o     = !in_access ? 4'b1111 : (write_q ? ~sel_q : 4'b0000);

endmodule
